mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, operand FIFO entries; power of two, at least 2.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  upstream operand pair valid.
REQ-005 Port: in_ready  output  1  FIFO can accept a pair.
REQ-006 Port: in_a, in_b  input  32 each  signed operands.
REQ-007 Port: in_last  input  1  pair closes the current dot product.
REQ-008 Port: mul_start  output  1  one-cycle start pulse to the sequential signed multiplier.
REQ-009 Port: mul_a, mul_b  output  32 each  signed operands to the multiplier, registered.
REQ-010 Port: mul_ready  input  1  multiplier done; low from the cycle after start until result is valid.
REQ-011 Port: mul_product  input  64  signed multiplier result; valid while mul_ready is high.
REQ-012 Port: out_valid  output  1  accumulated result available.
REQ-013 Port: out_ready  input  1  downstream accepts the result.
REQ-014 Port: out_acc  output  64  signed accumulated sum.
REQ-015 Port: out_ovf  output  1  sticky signed-overflow flag for this dot product.
REQ-016 Port: busy  output  1  high whenever the state is not IDLE or the FIFO is not empty.

Function
REQ-017 Operand FIFO: push when in_valid and in_ready; in_ready = not full, with no pass-through when full.
REQ-018 FIFO: a simultaneous push and pop leaves the count unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-019 FSM states: IDLE, ISSUE, WAIT, ACCUM, OUT.
REQ-020 IDLE: if the FIFO is not empty, pop the head; latch a, b and last into mul_a, mul_b and last_r; go to ISSUE. Otherwise stay in IDLE.
REQ-021 ISSUE: mul_start = 1 for exactly this cycle; go to WAIT.
REQ-022 WAIT: mul_start = 0. When mul_ready = 1, capture mul_product into prod_r and go to ACCUM. mul_ready is never sampled in the ISSUE cycle.
REQ-023 ACCUM: acc <= acc + prod_r in 64-bit two's complement, wrapping.
REQ-024 ACCUM overflow: ovf <= ovf OR (sign(acc) == sign(prod_r) AND sign(sum) != sign(acc)).
REQ-025 ACCUM exit: go to OUT if last_r, else IDLE.
REQ-026 OUT: out_valid = 1, and out_acc and out_ovf are held stable. When out_ready = 1, clear acc and ovf to 0 and go to IDLE.
REQ-027 out_valid is high only in OUT; out_acc = acc and out_ovf = ovf in all states.
REQ-028 mul_a and mul_b hold their values from ISSUE until the next pop.
REQ-029 Only one multiply is outstanding at a time. A new mul_start is issued no earlier than the second cycle after ACCUM.
REQ-030 Per-pair latency from pop to accumulate: 1 (ISSUE) + multiplier latency (32 cycles) + 1 (capture) + 1 (ACCUM).
REQ-031 The FIFO keeps accepting pushes in every state, including OUT while stalled; popping resumes only after OUT is left.
REQ-032 A pair with in_last = 1 and no preceding pairs yields out_acc = a*b.

Reset
REQ-033 While rst is high, all of the following hold: FSM = IDLE; FIFO empty with pointers 0; acc = 0; ovf = 0; mul_start = 0; mul_a = 0; mul_b = 0; out_valid = 0; busy = 0; in_ready = 1.
REQ-034 Reset asserted mid-operation (WAIT or OUT) discards the in-flight product and all queued pairs. No mul_start is issued until after reset deasserts and a new push occurs.

Verification
REQ-035 Single pair: push (3, -5, last=1) with a 32-cycle multiplier model -> exactly one mul_start pulse, then out_valid with out_acc = -15 and out_ovf = 0.
REQ-036 Dot product: pairs (2,3), (-4,5), (7,7, last) -> out_acc = 35. Exactly 3 start pulses, each pulse occurs only after the previous mul_ready capture.
REQ-037 Overflow: five pairs (-2^31, -2^31), last on the fifth -> out_acc = 0x4000000000000000 (wrapped) and out_ovf = 1. The next dot product, (1,1, last), yields 1 with ovf = 0.
REQ-038 Backpressure: out_ready = 0 for 10 cycles in OUT while pushing 3 pairs with FIFO_DEPTH = 2 -> in_ready drops after 2 pushes, out_acc is stable, and there is no mul_start until out_ready = 1.
REQ-039 FIFO concurrency: with count = 1, simultaneous push and pop in IDLE -> count stays 1. Ordering is preserved across pointer wrap over 6 pairs.
REQ-040 Reset in WAIT: assert rst 10 cycles after mul_start -> all outputs at reset values immediately (asynchronously). A later mul_ready pulse is ignored, and a new pair produces a correct result.

Source files
------------

// File: rtl/mac_sequencer.sv
// Queues signed operand pairs and drives a sequential multiplier, accumulating a wrapping 64-bit dot product.
// Per pair: issue + multiplier latency + capture + accumulate; in_ready = FIFO not full, result held until out_ready.

module mac_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   // Pointers are log2(DEPTH) bits wide, so the increment wraps modulo DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module mac_sequencer #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic        in_last,
   output logic        mul_start,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic        mul_ready,
   input  logic [63:0] mul_product,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_acc,
   output logic        out_ovf,
   output logic        busy
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACCUM, OUT} state_t;

   state_t      state;
   logic        fifo_full;
   logic        fifo_empty;
   logic        push;
   logic        pop;
   logic [64:0] head;
   logic        last_r;
   logic [63:0] prod_r;
   logic [63:0] acc;
   logic [63:0] sum;
   logic        ovf;
   logic        ovf_step;

   assign in_ready = !fifo_full;
   assign push     = in_valid && !fifo_full;
   assign pop      = (state == IDLE) && !fifo_empty;

   mac_fifo #(.WIDTH(65), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({in_last, in_a, in_b}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Signed overflow: operands of equal sign producing a sum of the other sign.
   assign sum      = acc + prod_r;
   assign ovf_step = (acc[63] == prod_r[63]) && (sum[63] != acc[63]);

   assign out_acc = acc;
   assign out_ovf = ovf;
   assign busy    = (state != IDLE) || !fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mul_start <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         last_r    <= 1'b0;
         prod_r    <= '0;
         acc       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  mul_a     <= head[63:32];
                  mul_b     <= head[31:0];
                  last_r    <= head[64];
                  mul_start <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               mul_start <= 1'b0;
               state     <= WAIT;
            end
            WAIT: begin
               if (mul_ready) begin
                  prod_r <= mul_product;
                  state  <= ACCUM;
               end
            end
            ACCUM: begin
               acc <= sum;
               ovf <= ovf | ovf_step;
               if (last_r) begin
                  out_valid <= 1'b1;
                  state     <= OUT;
               end else begin
                  state <= IDLE;
               end
            end
            OUT: begin
               if (out_ready) begin
                  acc       <= '0;
                  ovf       <= 1'b0;
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_start_pulse: assert property (@(posedge clk) disable iff (rst) mul_start |=> !mul_start);
   a_out_state:   assert property (@(posedge clk) disable iff (rst) out_valid |-> state == OUT);
   a_out_hold:    assert property (@(posedge clk) disable iff (rst)
                     (out_valid && !out_ready) |=> (out_valid && $stable(out_acc) && $stable(out_ovf)));
endmodule

// File: tb/tb_mac_sequencer.sv
// Drives mac_sequencer with directed and random operand streams against a transaction-level dot-product model.
module tb_mac_sequencer;
   localparam int DEPTH   = 2;
   localparam int MUL_LAT = 32;
   localparam logic signed [64:0] ACC_MAX = 65'sh0_7FFF_FFFF_FFFF_FFFF;
   localparam logic signed [64:0] ACC_MIN = -65'sh0_8000_0000_0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_last;
   logic [31:0] in_a, in_b;
   logic        mul_start, mul_ready;
   logic [31:0] mul_a, mul_b;
   logic [63:0] mul_product;
   logic        out_valid, out_ready, out_ovf, busy;
   logic [63:0] out_acc;

   always #5 clk = ~clk;

   mac_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_ready(mul_ready), .mul_product(mul_product),
      .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf), .busy(busy)
   );

   // Sequential multiplier: ready drops after start, result valid MUL_LAT cycles later.
   logic [63:0] m_prod = '0;
   int          m_cnt  = 0;
   always @(posedge clk) begin
      if (mul_start) begin
         m_prod <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
         m_cnt  <= MUL_LAT;
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
      end
   end
   assign mul_ready   = (m_cnt == 0);
   assign mul_product = m_prod;

   typedef struct { logic [31:0] a; logic [31:0] b; logic last; } pair_t;
   typedef struct { logic [63:0] acc; logic ovf; int start_cyc; } res_t;

   pair_t       pend[$];
   res_t        exp_q[$];
   logic [63:0] m_acc = '0;
   logic        m_ovf = 1'b0;
   int          checks = 0, errors = 0, cyc = 0, start_cnt = 0, out_cnt = 0, prev_start = -1000;
   logic [31:0] cur_a = '0, cur_b = '0;
   logic        prev_ov = 1'b0;
   logic [63:0] last_acc = '0;
   logic        last_ovf = 1'b0;
   logic        rand_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event missing or unexpected", name);
   endtask

   always @(negedge clk) begin : mon
      pair_t             p;
      res_t              r;
      int                fc;
      logic [63:0]       prod;
      logic signed [64:0] ex;
      cyc++;
      if (rst) begin
         pend.delete();
         exp_q.delete();
         m_acc = '0; m_ovf = 1'b0; cur_a = '0; cur_b = '0;
         prev_start = -1000; prev_ov = 1'b0;
      end else begin
         fc = pend.size() - (mul_start ? 1 : 0);
         chk("in_ready", in_ready, fc < DEPTH);
         if (fc > 0) chk("busy", busy, 1'b1);
         if (mul_start) begin
            if (pend.size() == 0) fail("unexpected_start");
            else begin
               p = pend.pop_front();
               chk("mul_a", mul_a, p.a);
               chk("mul_b", mul_b, p.b);
               chk("start_gap", (cyc - prev_start) >= 36, 1'b1);
               prev_start = cyc;
               start_cnt++;
               cur_a = p.a; cur_b = p.b;
               prod = longint'($signed(p.a)) * longint'($signed(p.b));
               ex   = $signed({m_acc[63], m_acc}) + $signed({prod[63], prod});
               if (ex > ACC_MAX || ex < ACC_MIN) m_ovf = 1'b1;
               m_acc = ex[63:0];
               if (p.last) begin
                  r.acc = m_acc; r.ovf = m_ovf; r.start_cyc = cyc;
                  exp_q.push_back(r);
                  m_acc = '0; m_ovf = 1'b0;
               end
            end
         end else begin
            chk("mul_a_hold", mul_a, cur_a);
            chk("mul_b_hold", mul_b, cur_b);
         end
         if (out_valid) begin
            if (exp_q.size() == 0) fail("unexpected_out_valid");
            else begin
               chk("out_acc", out_acc, exp_q[0].acc);
               chk("out_ovf", out_ovf, exp_q[0].ovf);
               if (!prev_ov) chk("latency", cyc - exp_q[0].start_cyc, 35);
               if (out_ready) begin
                  last_acc = out_acc;
                  last_ovf = out_ovf;
                  out_cnt++;
                  void'(exp_q.pop_front());
               end
            end
         end
         prev_ov = out_valid;
         if (in_valid && in_ready) begin
            p.a = in_a; p.b = in_b; p.last = in_last;
            pend.push_back(p);
         end
      end
   end

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic last);
      int n = 0;
      in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
      do begin @(negedge clk); n++; end while (!in_ready && n < 2000);
      if (!in_ready) fail("push_timeout");
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      do begin @(negedge clk); n++; end
      while ((busy || out_valid || exp_q.size() != 0 || pend.size() != 0) && n < 3000);
      if (n >= 3000) fail(name);
      @(posedge clk); #1;
   endtask

   initial forever begin
      @(posedge clk); #1;
      if (rand_en) out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin : stim
      int s;
      int n;
      int oc;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      chk("rst_mul_start", mul_start, 1'b0);
      chk("rst_mul_a", mul_a, 32'h0);
      chk("rst_mul_b", mul_b, 32'h0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_acc", out_acc, 64'h0);
      chk("rst_out_ovf", out_ovf, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Single pair
      s = start_cnt;
      push(32'd3, -32'sd5, 1'b1);
      wait_idle("single_timeout");
      chk("single_acc", last_acc, -64'sd15);
      chk("single_ovf", last_ovf, 1'b0);
      chk("single_starts", start_cnt - s, 1);

      // Three-term dot product
      s = start_cnt;
      push(32'd2, 32'd3, 1'b0);
      push(-32'sd4, 32'd5, 1'b0);
      push(32'd7, 32'd7, 1'b1);
      wait_idle("dot_timeout");
      chk("dot_acc", last_acc, 64'd35);
      chk("dot_starts", start_cnt - s, 3);

      // Wrapping accumulation with sticky overflow, then a clean product
      for (int i = 0; i < 5; i++) push(32'h8000_0000, 32'h8000_0000, i == 4);
      wait_idle("ovf_timeout");
      chk("ovf_acc", last_acc, 64'h4000_0000_0000_0000);
      chk("ovf_flag", last_ovf, 1'b1);
      push(32'd1, 32'd1, 1'b1);
      wait_idle("ovf_clear_timeout");
      chk("after_ovf_acc", last_acc, 64'd1);
      chk("after_ovf_flag", last_ovf, 1'b0);

      // Stall in OUT while the FIFO fills
      out_ready = 1'b0;
      push(32'd1, 32'd2, 1'b1);
      n = 0;
      do begin @(negedge clk); n++; end while (!out_valid && n < 100);
      if (!out_valid) fail("stall_out_timeout");
      @(posedge clk); #1;
      s = start_cnt;
      push(32'd4, 32'd4, 1'b0);
      push(32'd5, 32'd5, 1'b0);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_acc", out_acc, 64'd2);
      fork
         push(32'd6, 32'd6, 1'b1);
         begin
            repeat (8) @(posedge clk);
            #1;
            chk("stall_no_start", start_cnt - s, 0);
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_acc_held", out_acc, 64'd2);
            out_ready = 1'b1;
         end
      join
      wait_idle("stall_timeout");
      chk("stall_next_acc", last_acc, 64'd77);

      // Back-to-back pushes wrap the pointers several times
      s = start_cnt;
      for (int i = 1; i <= 6; i++) push(32'(i), 32'(i), i == 6);
      wait_idle("wrap_timeout");
      chk("wrap_acc", last_acc, 64'd91);
      chk("wrap_starts", start_cnt - s, 6);

      // Reset while waiting on the multiplier
      s = start_cnt;
      push(32'd6, 32'd7, 1'b0);
      push(32'd100, -32'sd7, 1'b1);
      n = 0;
      do begin @(negedge clk); n++; end while (start_cnt != s + 2 && n < 200);
      if (start_cnt != s + 2) fail("rst_start_timeout");
      repeat (10) @(posedge clk);
      #1;
      chk("acc_before_rst", out_acc, 64'd42);
      #1 rst = 1'b1;
      #1;
      chk("rst_wait_mul_start", mul_start, 1'b0);
      chk("rst_wait_mul_a", mul_a, 32'h0);
      chk("rst_wait_busy", busy, 1'b0);
      chk("rst_wait_in_ready", in_ready, 1'b1);
      chk("rst_wait_out_acc", out_acc, 64'h0);
      chk("rst_wait_out_valid", out_valid, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      s = start_cnt;
      repeat (40) @(posedge clk);
      #1;
      chk("rst_no_restart", start_cnt - s, 0);
      chk("rst_idle_busy", busy, 1'b0);
      push(32'd9, 32'd9, 1'b1);
      wait_idle("post_rst_timeout");
      chk("post_rst_acc", last_acc, 64'd81);

      // Randomized dot products with random output backpressure
      oc = out_cnt;
      rand_en = 1'b1;
      for (int d = 0; d < 15; d++) begin
         int len;
         len = $urandom_range(1, 4);
         for (int k = 0; k < len; k++) begin
            logic [31:0] a, b;
            case ($urandom_range(0, 3))
               0:       begin a = $urandom; b = $urandom; end
               1:       begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF; end
               default: begin a = $urandom_range(0, 200) - 100; b = $urandom_range(0, 200) - 100; end
            endcase
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            push(a, b, k == len - 1);
         end
      end
      wait_idle("random_timeout");
      rand_en = 1'b0;
      @(posedge clk); #2;
      out_ready = 1'b1;
      chk("random_results", out_cnt - oc, 15);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
